// File: rtl/hmi_mux.sv
// Human-machine input merger: PS2 keyboard map plus joystick routing into one registered hmi_t.
// Autofire is compiled in only when HMI_MUX_TURBO_EN is defined.

package hmi_pkg;

    typedef struct packed {
        logic t2;
        logic t1;
        logic u;
        logic d;
        logic l;
        logic r;
    } ctrl_t;

    typedef struct packed {
        logic       pause;
        logic [9:0] num;
        logic       cl;
        logic       en;
        ctrl_t      c1;
        ctrl_t      c2;
    } hmi_t;

endpackage

module hmi_mux #(
    parameter int NUM_JOY    = 2,
    parameter int TURBO_TICK = 400000
) (
    input  logic                     CLK_SYS,
    input  logic                     RESB,
    input  logic [NUM_JOY-1:0][31:0] JOYSTICK,
    input  logic [10:0]              PS2_KEY,
    input  logic                     SWAP,
    input  logic [1:0]               TURBO_RATE,
    output hmi_pkg::hmi_t            HMI
);
    import hmi_pkg::*;

    hmi_t       kb_q, kb_d;
    hmi_t       hmi_q, hmi_d;
    logic       ps2_tog_q, ps2_tog_d;
    logic       ps2_armed_q, ps2_armed_d;
    logic       ps2_event;
    logic       ps2_press;
    ctrl_t      joy_c1, joy_c2;
    logic [3:0] joy_num;
    logic       joy_en;
    // Turbo unit index: 0 = c1.t1, 1 = c1.t2, 2 = c2.t1, 3 = c2.t2
    logic [3:0] turbo_held;
    logic [3:0] turbo_fire;
    logic       unused_inputs;

    always_comb begin
        ps2_tog_d   = PS2_KEY[10];
        ps2_armed_d = 1'b1;
        ps2_event   = ps2_armed_q && (PS2_KEY[10] != ps2_tog_q);
        ps2_press   = PS2_KEY[9];
        kb_d        = kb_q;
        if (ps2_event) begin
            case (PS2_KEY[8:0])
                9'h005:         kb_d.pause  = ps2_press;
                9'h045, 9'h070: kb_d.num[0] = ps2_press;
                9'h016, 9'h069: kb_d.num[1] = ps2_press;
                9'h01E, 9'h072: kb_d.num[2] = ps2_press;
                9'h026, 9'h07A: kb_d.num[3] = ps2_press;
                9'h025, 9'h06B: kb_d.num[4] = ps2_press;
                9'h02E, 9'h073: kb_d.num[5] = ps2_press;
                9'h036, 9'h074: kb_d.num[6] = ps2_press;
                9'h03D, 9'h06C: kb_d.num[7] = ps2_press;
                9'h03E, 9'h075: kb_d.num[8] = ps2_press;
                9'h046, 9'h07D: kb_d.num[9] = ps2_press;
                9'h066, 9'h071: kb_d.cl     = ps2_press;
                9'h05A, 9'h15A: kb_d.en     = ps2_press;
                9'h175:         kb_d.c1.u   = ps2_press;
                9'h172:         kb_d.c1.d   = ps2_press;
                9'h16B:         kb_d.c1.l   = ps2_press;
                9'h174:         kb_d.c1.r   = ps2_press;
                9'h029:         kb_d.c1.t1  = ps2_press;
                9'h014:         kb_d.c1.t2  = ps2_press;
                default:        ;
            endcase
        end
    end

    // Even joysticks feed controller 1 and odd ones controller 2, exchanged by SWAP.
    always_comb begin
        joy_c1     = '0;
        joy_c2     = '0;
        joy_num    = '0;
        joy_en     = 1'b0;
        turbo_held = '0;
        for (int k = 0; k < NUM_JOY; k++) begin
            if (((k % 2) == 1) != SWAP) begin
                joy_c2           = joy_c2 | JOYSTICK[k][5:0];
                turbo_held[3:2]  = turbo_held[3:2] | JOYSTICK[k][12:11];
            end else begin
                joy_c1           = joy_c1 | JOYSTICK[k][5:0];
                turbo_held[1:0]  = turbo_held[1:0] | JOYSTICK[k][12:11];
            end
            joy_num = joy_num | JOYSTICK[k][9:6];
            joy_en  = joy_en | JOYSTICK[k][10];
        end
    end

`ifdef HMI_MUX_TURBO_EN
    localparam int CNT_W = $clog2(TURBO_TICK * 8 + 1);

    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0][1:0]       rate_q, rate_d;
    logic [3:0]            phase_q, phase_d;

    // A zero count marks an idle unit; the rate is latched per half-period.
    always_comb begin
        cnt_d   = cnt_q;
        rate_d  = rate_q;
        phase_d = phase_q;
        for (int u = 0; u < 4; u++) begin
            if (!turbo_held[u]) begin
                cnt_d[u]   = '0;
                phase_d[u] = 1'b0;
            end else if (cnt_q[u] == '0) begin
                cnt_d[u]   = CNT_W'(1);
                phase_d[u] = 1'b1;
                rate_d[u]  = TURBO_RATE;
            end else if (cnt_q[u] == (CNT_W'(TURBO_TICK) << rate_q[u])) begin
                cnt_d[u]   = CNT_W'(1);
                phase_d[u] = ~phase_q[u];
                rate_d[u]  = TURBO_RATE;
            end else begin
                cnt_d[u]   = cnt_q[u] + CNT_W'(1);
            end
        end
        turbo_fire = phase_d;
    end

    always_ff @(posedge CLK_SYS or negedge RESB) begin
        if (!RESB) begin
            cnt_q   <= '0;
            rate_q  <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            phase_q <= phase_d;
        end
    end

    assign unused_inputs = ^JOYSTICK;
`else
    assign turbo_fire    = '0;
    assign unused_inputs = ^{JOYSTICK, TURBO_RATE, turbo_held, (TURBO_TICK > 0)};
`endif

    always_comb begin
        hmi_d          = kb_q;
        hmi_d.num[4:1] = kb_q.num[4:1] | joy_num;
        hmi_d.en       = kb_q.en | joy_en;
        hmi_d.c1       = kb_q.c1 | joy_c1;
        hmi_d.c2       = kb_q.c2 | joy_c2;
        hmi_d.c1.t1    = hmi_d.c1.t1 | turbo_fire[0];
        hmi_d.c1.t2    = hmi_d.c1.t2 | turbo_fire[1];
        hmi_d.c2.t1    = hmi_d.c2.t1 | turbo_fire[2];
        hmi_d.c2.t2    = hmi_d.c2.t2 | turbo_fire[3];
    end

    // The first edge out of reset only samples the PS2 toggle, so no event is replayed.
    always_ff @(posedge CLK_SYS or negedge RESB) begin
        if (!RESB) begin
            kb_q        <= '0;
            hmi_q       <= '0;
            ps2_tog_q   <= 1'b0;
            ps2_armed_q <= 1'b0;
        end else begin
            kb_q        <= kb_d;
            hmi_q       <= hmi_d;
            ps2_tog_q   <= ps2_tog_d;
            ps2_armed_q <= ps2_armed_d;
        end
    end

    assign HMI = hmi_q;

endmodule

// File: doc/hmi_mux.md
HMI_MUX -- requirements
Module: hmi_mux

Interface
REQ-001 Parameter NUM_JOY, default 2, number of joystick inputs (1..4).
REQ-002 Parameter TURBO_TICK, default 400000, base CLK_SYS cycles per autofire half-period.
REQ-003 CLK_SYS  in  1  system clock; all state changes on its rising edge.
REQ-004 RESB  in  1  reset; asynchronous, active-low.
REQ-005 JOYSTICK  in  NUM_JOY x 32  packed joystick words; bits 5:0 = t2,t1,u,d,l,r; 9:6 = num4..num1; 10 = en; 11 = turbo-t1; 12 = turbo-t2.
REQ-006 PS2_KEY  in  11  bit 10 toggles per event, bit 9 pressed, bits 8:0 extended-flag + scancode.
REQ-007 SWAP  in  1  exchanges controller 1 and controller 2 routing.
REQ-008 TURBO_RATE  in  2  autofire half-period = TURBO_TICK << TURBO_RATE cycles.
REQ-009 HMI  out  hmi_t  registered merged human-machine input to the console core.

Function
REQ-010 A PS2 event SHALL be detected when PS2_KEY[10] differs from its registered copy; each event SHALL be processed exactly once.
REQ-011 Keyboard map SHALL be: F1 (005) pause; 045/070..046/07D num[0..9] (main row and keypad); 066/071 cl; 05A/15A en; 175/172/16B/174 c1 u/d/l/r; 029 (Space) c1.t1; 014 (LCtrl) c1.t2; other codes ignored.
REQ-012 Each mapped keyboard bit SHALL be set on a press event and cleared on a release event of that code; bits SHALL hold otherwise.
REQ-013 Joystick k SHALL drive controller ((k mod 2) XOR SWAP)+1; multiple sources for one controller bit SHALL be OR-ed together and with the keyboard bit.
REQ-014 JOYSTICK[k][9:6] SHALL OR into num[4:1] and JOYSTICK[k][10] into en for every k, independent of SWAP.
REQ-015 Autofire: per controller and per trigger, a turbo source held SHALL produce a square wave of half-period TURBO_TICK << TURBO_RATE cycles, OR-ed with the plain trigger.
REQ-016 Autofire phase SHALL start high on the first cycle a turbo source becomes held, and return to idle (low, counter cleared) when no turbo source for that trigger is held.
REQ-017 A TURBO_RATE change SHALL take effect at the next half-period boundary; the running count SHALL not be truncated mid-period.
REQ-018 Latency: JOYSTICK change before edge N SHALL appear on HMI after edge N; PS2 event present before edge N SHALL appear on HMI after edge N+1.
REQ-019 PS2 event and joystick change for the same HMI bit in the same cycle SHALL both take effect (OR), with no lost event.
REQ-020 Controller bits u/d and l/r SHALL pass through unfiltered (opposing directions may both be 1).

Reset
REQ-021 While RESB is low, HMI, all keyboard bits, turbo counters and turbo phases SHALL be 0.
REQ-022 On the first CLK_SYS edge after RESB rises, the PS2 toggle copy SHALL be loaded from PS2_KEY[10] without processing an event.
REQ-023 Reset asserted mid-operation SHALL clear held keyboard keys; keys still physically held stay released until their next press event.

Configuration
REQ-024 Macro HMI_MUX_TURBO_EN SHALL compile autofire in; undefined, turbo bits 11/12 SHALL be ignored, TURBO_RATE unused, and no turbo counters synthesised.

Verification
REQ-025 Reset with PS2_KEY[10]=1 -> release RESB -> HMI stays 0 for 4 cycles (no spurious event).
REQ-026 PS2_KEY toggles with 0x216 (press '1') -> HMI.num[1]=1 two edges later; toggle with 0x016 (release) -> num[1]=0.
REQ-027 NUM_JOY=2, JOYSTICK[0]=0x001, SWAP=0 -> HMI.c1.r=1, c2.r=0; SWAP=1 -> c2.r=1, c1.r=0 after one edge.
REQ-028 TURBO_TICK=4, TURBO_RATE=1, JOYSTICK[0][11]=1 held 40 cycles -> c1.t1 high 8, low 8, repeating from first held cycle; release -> t1=0 next edge.
REQ-029 Same cycle: JOYSTICK[1][10]=1 and PS2 Enter release -> HMI.en=1 from joystick; joystick clear -> en=0.
REQ-030 Build without HMI_MUX_TURBO_EN, JOYSTICK[0][12]=1 -> c1.t2 stays 0.
